// File: rtl/coin_collector.sv
// coin_collector: per-level coin state tracker. Samples the player/coin
// overlap once per video frame, drives coin visibility, a one-cycle pickup
// pulse, the exit-enable flag and a saturating lifetime pickup count.
module coin_collector #(
    parameter int SYNC_STAGES = 2,
    parameter int TOTAL_W     = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               Level1_Active,
    input  logic               Level2_Active,
    input  logic               Level3_Active,
    input  logic [9:0]         CoinX,
    input  logic [9:0]         CoinY,
    input  logic [9:0]         CoinS,
    input  logic [9:0]         PlayerX,
    input  logic [9:0]         PlayerY,
    input  logic [9:0]         PlayerS,
    input  logic               Player_Dead,
    output logic               Coin_Visible,
    output logic               Coin_Pickup,
    output logic               Exit_Enable,
    output logic [TOTAL_W-1:0] Coins_Total
);

    typedef enum logic [1:0] {
        HIDDEN    = 2'd0,
        ARMED     = 2'd1,
        COLLECTED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   pickup_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_out;
    logic                   frame_tick;
    logic [2:0]             level_vec, lvl_q;
    logic                   level_change;
    logic signed [10:0]     diff_x, diff_y;
    logic [10:0]            dx, dy, lim;
    logic                   overlap;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign frame_tick   = sync_out & ~prev_q;
    assign level_vec    = {Level3_Active, Level2_Active, Level1_Active};
    assign level_change = (level_vec != lvl_q);

    // Box overlap on centre distance; the edge-touching case counts as a hit
    always_comb begin
        diff_x  = $signed({1'b0, PlayerX}) - $signed({1'b0, CoinX});
        diff_y  = $signed({1'b0, PlayerY}) - $signed({1'b0, CoinY});
        dx      = diff_x[10] ? $unsigned(-diff_x) : $unsigned(diff_x);
        dy      = diff_y[10] ? $unsigned(-diff_y) : $unsigned(diff_y);
        lim     = {1'b0, PlayerS} + {1'b0, CoinS};
        overlap = (dx <= lim) && (dy <= lim);
    end

    // frame_clk synchronizer chain plus edge-detect flop
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], frame_clk};
            prev_q <= sync_out;
        end
    end

    // Next-state selection, highest-priority rule first
    always_comb begin
        state_d  = state_q;
        pickup_d = 1'b0;
        if (level_vec == '0) begin
            state_d = HIDDEN;
        end else if (level_change) begin
            state_d = ARMED;
        end else if (state_q == COLLECTED && Player_Dead) begin
            state_d = ARMED;
        end else if (state_q == ARMED && frame_tick && overlap && !Player_Dead) begin
            state_d  = COLLECTED;
            pickup_d = 1'b1;
        end
    end

    // State, level history, pickup pulse and saturating pickup count
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= HIDDEN;
            lvl_q       <= '0;
            Coin_Pickup <= 1'b0;
            Coins_Total <= '0;
        end else begin
            state_q     <= state_d;
            lvl_q       <= level_vec;
            Coin_Pickup <= pickup_d;
            if (Coin_Pickup && (Coins_Total != '1))
                Coins_Total <= Coins_Total + 1'b1;
        end
    end

    assign Coin_Visible = (state_q == ARMED);
    assign Exit_Enable  = (state_q == COLLECTED);

endmodule

// File: doc/coin_collector.md
# coin_collector

Coin pickup tracker that sits directly downstream of the coin position generator. It consumes the coin centre and size plus the player box, and detects overlap once per video frame. It holds the per-level coin state (hidden / armed / collected) and drives coin visibility to the renderer, a pickup pulse, and the exit-enable flag to level control. Death before exit re-arms the coin, which matches game rules.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the frame_clk synchronizer (minimum 2)
- TOTAL_W, 8, width of the lifetime pickup counter

Ports:
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- frame_clk  in  1  vsync-rate strobe, asynchronous to Clk
- Level1_Active, Level2_Active, Level3_Active  in  1 each  level select; none high means no level is running
- CoinX, CoinY  in  10  coin centre (pixels)
- CoinS  in  10  coin half-size
- PlayerX, PlayerY  in  10  player centre
- PlayerS  in  10  player half-size
- Player_Dead  in  1  level-sensitive death indication from the player/enemy logic
- Coin_Visible  out  1  renderer draws the coin when high
- Coin_Pickup  out  1  one-Clk pulse on collection
- Exit_Enable  out  1  high while the coin is held
- Coins_Total  out  TOTAL_W  saturating lifetime pickup count

## Operation
- The frame_clk synchronizer is SYNC_STAGES flops followed by one `prev` flop. frame_tick = sync_out & ~prev. This gives one Clk-wide tick per frame_clk rising edge.
- Overlap test, combinational, registered into state only on frame_tick:
  - dx = |PlayerX − CoinX| and dy = |PlayerY − CoinY|, each computed as an 11-bit signed difference, then its absolute value.
  - lim = PlayerS + CoinS, computed 11 bits wide with no truncation.
  - overlap = (dx ≤ lim) && (dy ≤ lim). The boundary is inclusive.
- level_vec = {Level3_Active, Level2_Active, Level1_Active}, registered each Clk as lvl_q. level_change = (level_vec ≠ lvl_q).
- State machine: HIDDEN, ARMED, COLLECTED. Rules are evaluated per Clk in this priority order:
  1. level_vec == 0 → HIDDEN.
  2. level_change with level_vec ≠ 0 → ARMED. This covers HIDDEN→ARMED on level start and any state→ARMED on level switch.
  3. State COLLECTED and Player_Dead → ARMED.
  4. State ARMED, frame_tick, overlap, and !Player_Dead → COLLECTED, with Coin_Pickup = 1 for the next cycle.
  5. Otherwise, hold.
- Outputs:
  - Coin_Visible = (state == ARMED).
  - Exit_Enable = (state == COLLECTED).
  - Coin_Pickup is a registered pulse.
- Coins_Total increments by 1 per Coin_Pickup and saturates at all-ones. Only Reset clears it; level changes and death do not.
- A pickup after death and re-arm counts again.

## Timing
- Reset values:
  - state = HIDDEN, lvl_q = 0, synchronizer and prev = 0.
  - Coin_Visible = 0, Coin_Pickup = 0, Exit_Enable = 0, Coins_Total = 0.
- Reset mid-frame or mid-pickup aborts immediately. No pending pickup survives.
- Latency with SYNC_STAGES = 2: frame_clk rises before Clk edge E1, and frame_tick is high between E2 and E3. The state change and the Coin_Pickup assertion are both visible after E3. Coin_Pickup deasserts after E4.
- Level start: level_vec goes nonzero before edge E, and Coin_Visible = 1 after E.
- Death re-arm takes one Clk and does not wait for a tick.
- Death and overlap on the same tick: death wins. The state stays ARMED and there is no pulse.
- frame_clk held high produces only one tick. Glitches shorter than a Clk period may be missed, and that is acceptable.
- Player or coin inputs changing between ticks have no effect. Only the values present on the tick cycle are used.
- Coins_Total at saturation: the pickup pulse still fires and the count holds.

## Test plan
- Reset, then Level1_Active=1: Coin_Visible=1 after one edge, Exit_Enable=0, Coins_Total=0.
- Coin (320,240,S=3) and player (330,240,S=7), dx=10=lim, then a frame_clk edge: Coin_Pickup pulses once, 3 Clks after frame_clk rises. Coin_Visible=0, Exit_Enable=1, Coins_Total=1. The same setup with player X=331 gives no pickup.
- While COLLECTED, assert Player_Dead for 1 Clk: the next cycle shows Coin_Visible=1 and Exit_Enable=0. A second pickup gives Coins_Total=2.
- Player_Dead=1 during an overlapping tick: no pulse and the state stays ARMED. A level switch from Level1 to Level3 while COLLECTED → ARMED. Dropping all levels → HIDDEN, with all flags 0.
- Reset asserted asynchronously during COLLECTED: all outputs are 0 without waiting for a Clk edge. Force 255 pickups with TOTAL_W=8, then one more: Coins_Total stays 255 and Coin_Pickup still pulses.
